// File: rtl/mem_pkg.sv
// Shared constants and FSM state type for the data memory responder.
package mem_pkg;
  localparam int MEM_DEPTH = 32;
  localparam int ADDR_W    = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/dmem_byte_array.sv
// 32-byte storage, big-endian word view: byte at word base holds bits 31:24.
module dmem_byte_array import mem_pkg::*; #(
  parameter int DEPTH = MEM_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_we,
  input  logic [2:0]  i_word,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_be,
  output logic [31:0] o_rdata
);
  logic [7:0] r_mem [DEPTH];

  // be[b] covers wdata[8b+7:8b], which lives at byte offset 3-b in the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= 8'h00;
    end else if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[{i_word, 2'(3 - b)}] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = {r_mem[{i_word, 2'd0}], r_mem[{i_word, 2'd1}],
                    r_mem[{i_word, 2'd2}], r_mem[{i_word, 2'd3}]};
endmodule

// File: rtl/data_mem_responder.sv
// Request/response memory responder: one outstanding access, fixed wait
// latency, misaligned accesses flagged with rsp_err and no side effects.
module data_mem_responder import mem_pkg::*; #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH       = MEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [1:0]        dbg_state
);
  // Handshakes: a request transfers on an edge where req_valid && req_ready;
  // a response transfers on an edge where rsp_valid && rsp_ready. Payloads
  // are held stable by their source until the transferring edge.
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t              r_state, w_next_state;
  logic [3:0]          r_cnt;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [3:0]          r_be;
  logic                r_rsp_valid, r_rsp_err;
  logic [31:0]         r_rsp_rdata;
  logic                w_accept, w_enter_resp, w_rsp_done;
  logic                w_op_write, w_op_err, w_mem_we;
  logic [ADDR_W-1:0]   w_op_addr;
  logic [31:0]         w_op_wdata, w_mem_rdata;
  logic [3:0]          w_op_be;

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_enter_resp = 1'b0;
    w_rsp_done   = 1'b0;
    case (r_state)
      IDLE: if (req_valid) begin
        w_accept = 1'b1;
        if (WAIT_CYCLES == 0) begin
          w_next_state = RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_next_state = WAIT;
        end
      end
      WAIT: if (r_cnt == 4'd0) begin
        w_next_state = RESP;
        w_enter_resp = 1'b1;
      end
      RESP: if (rsp_ready) begin
        w_next_state = IDLE;
        w_rsp_done   = 1'b1;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // With no wait cycles RESP is entered on the accept edge, so the live
  // request fields are used instead of the not-yet-captured copies.
  assign w_op_write = (r_state == IDLE) ? req_write : r_write;
  assign w_op_addr  = (r_state == IDLE) ? req_addr  : r_addr;
  assign w_op_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
  assign w_op_be    = (r_state == IDLE) ? req_be    : r_be;
  assign w_op_err   = (w_op_addr[1:0] != 2'b00);
  assign w_mem_we   = w_enter_resp && w_op_write && !w_op_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= 32'h0;
      r_be        <= 4'h0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
        r_cnt   <= CNT_INIT;
      end else if (r_state == WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter_resp) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_op_err;
        r_rsp_rdata <= (w_op_write || w_op_err) ? 32'h0 : w_mem_rdata;
      end else if (w_rsp_done) begin
        r_rsp_valid <= 1'b0;
        r_rsp_err   <= 1'b0;
        r_rsp_rdata <= 32'h0;
      end
    end
  end

  dmem_byte_array #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_mem_we),
    .i_word  (w_op_addr[4:2]),
    .i_wdata (w_op_wdata),
    .i_be    (w_op_be),
    .o_rdata (w_mem_rdata)
  );

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a WAIT_CYCLES=2 instance (index 0) and a
// WAIT_CYCLES=0 instance (index 1), each checked against a byte-array model.
module tb_data_mem_responder;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [4:0]  req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic [1:0]  dbg_state [2];

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  ref_mem [2][32];
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  int          wait_of [2] = '{2, 0};

  always #5 clk = ~clk;

  data_mem_responder #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .dbg_state(dbg_state[0])
  );

  data_mem_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .dbg_state(dbg_state[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void clear_model();
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 32; a++) ref_mem[d][a] = 8'h00;
  endfunction

  // Memory is a flat byte array; the byte at the word address is the most
  // significant, and be[3] enables that byte.
  function automatic void model_apply(input int d, input logic wr, input logic [4:0] addr,
                                      input logic [31:0] wdata, input logic [3:0] be,
                                      output logic [31:0] rd, output logic e);
    int base = int'(addr);
    e  = (base % 4) != 0;
    rd = 32'h0;
    if (e) return;
    for (int k = 0; k < 4; k++) begin
      if (wr) begin
        if (be[3 - k]) ref_mem[d][base + k] = wdata[31 - 8*k -: 8];
      end else begin
        rd = (rd << 8) | 32'(ref_mem[d][base + k]);
      end
    end
  endfunction

  task automatic drive_noise(input int d);
    req_valid[d] = 1'($urandom_range(0, 1));
    req_write[d] = 1'($urandom_range(0, 1));
    req_addr[d]  = 5'($urandom_range(0, 31));
    req_wdata[d] = $urandom;
    req_be[d]    = 4'($urandom_range(0, 15));
    rsp_ready[d] = 1'($urandom_range(0, 1));
  endtask

  task automatic do_txn(input int d, input logic wr, input logic [4:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input int stall, input bit noise,
                        output logic [31:0] got_rd, output logic got_err);
    logic [31:0] exp_rd, held;
    logic        exp_e;
    int          lat;
    model_apply(d, wr, addr, wdata, be, exp_rd, exp_e);
    exp_q.push_back(exp_rd);
    exp_err_q.push_back(exp_e);
    got_rd  = 32'hx;
    got_err = 1'bx;
    check("req_ready_before_req", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = addr;
    req_wdata[d] = wdata; req_be[d] = be;
    rsp_ready[d] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    @(posedge clk); #1;
    lat = 1;
    if (noise) drive_noise(d); else req_valid[d] = 1'b0;
    while (!rsp_valid[d] && lat < 40) begin
      check("req_ready_low_while_busy", 32'(req_ready[d]), 32'd0);
      @(posedge clk); #1;
      lat++;
      if (noise) drive_noise(d);
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b0;
    if (!rsp_valid[d]) begin
      check("rsp_valid_timeout", 32'(rsp_valid[d]), 32'd1);
      void'(exp_q.pop_front());
      void'(exp_err_q.pop_front());
      return;
    end
    check("latency_edges", 32'(lat), 32'(wait_of[d] + 1));
    got_rd  = rsp_rdata[d];
    got_err = rsp_err[d];
    check("rsp_rdata", got_rd, exp_q.pop_front());
    check("rsp_err", 32'(got_err), 32'(exp_err_q.pop_front()));
    held = got_rd;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("stall_rsp_valid", 32'(rsp_valid[d]), 32'd1);
      check("stall_rsp_rdata", rsp_rdata[d], held);
      check("stall_rsp_err", 32'(rsp_err[d]), 32'(got_err));
      check("stall_req_ready", 32'(req_ready[d]), 32'd0);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    check("rsp_valid_after_hs", 32'(rsp_valid[d]), 32'd0);
    check("req_ready_after_hs", 32'(req_ready[d]), 32'd1);
  endtask

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  initial begin
    vec_t        vecs[10];
    logic [31:0] rd;
    logic        er;
    bit          spurious;

    vecs[0] = '{1'b1, 5'd8,  32'hDEADBEEF, 4'hF,    32'h0,        1'b0};
    vecs[1] = '{1'b0, 5'd8,  32'h0,        4'h0,    32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 5'd4,  32'h11223344, 4'b0101, 32'h0,        1'b0};
    vecs[3] = '{1'b0, 5'd4,  32'h0,        4'h0,    32'h00220044, 1'b0};
    vecs[4] = '{1'b0, 5'd6,  32'h0,        4'h0,    32'h0,        1'b1};
    vecs[5] = '{1'b1, 5'd6,  32'hFFFFFFFF, 4'hF,    32'h0,        1'b1};
    vecs[6] = '{1'b0, 5'd4,  32'h0,        4'h0,    32'h00220044, 1'b0};
    vecs[7] = '{1'b1, 5'd12, 32'hAAAAAAAA, 4'h0,    32'h0,        1'b0};
    vecs[8] = '{1'b0, 5'd12, 32'h0,        4'h0,    32'h0,        1'b0};
    vecs[9] = '{1'b0, 5'd11, 32'h0,        4'h0,    32'h0,        1'b1};

    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0;   req_be[d] = '0;      rsp_ready[d] = 1'b0;
    end
    clear_model();

    // Reset held: outputs idle, ready asserted.
    rst_n = 1'b0;
    #12;
    for (int d = 0; d < 2; d++) begin
      check("reset_req_ready", 32'(req_ready[d]), 32'd1);
      check("reset_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      check("reset_rsp_rdata", rsp_rdata[d], 32'd0);
      check("reset_rsp_err", 32'(rsp_err[d]), 32'd0);
      check("reset_state", 32'(dbg_state[d]), 32'(IDLE));
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      do_txn(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, 0, 1'b0, rd, er);
      check("vec_rdata", rd, vecs[i].exp_rd);
      check("vec_err", 32'(er), 32'(vecs[i].exp_err));
    end

    // Five cycles of response backpressure on a load.
    do_txn(0, 1'b0, 5'd8, 32'h0, 4'h0, 5, 1'b0, rd, er);
    check("bp_rdata", rd, 32'hDEADBEEF);

    // Reset during WAIT of a store to address 0 aborts it.
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 5'd0;
    req_wdata[0] = 32'h12345678; req_be[0] = 4'hF;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("abort_in_wait", 32'(dbg_state[0]), 32'(WAIT));
    rst_n = 1'b0;
    #1;
    check("async_rst_state", 32'(dbg_state[0]), 32'(IDLE));
    check("async_rst_req_ready", 32'(req_ready[0]), 32'd1);
    check("async_rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    spurious = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid[0]) spurious = 1'b1;
    end
    check("no_spurious_rsp", 32'(spurious), 32'd0);
    do_txn(0, 1'b0, 5'd0, 32'h0, 4'h0, 0, 1'b0, rd, er);
    check("after_abort_load0", rd, 32'h0);

    // Zero-wait instance: store then load at the top word.
    do_txn(1, 1'b1, 5'd28, 32'hCAFEF00D, 4'hF, 0, 1'b0, rd, er);
    do_txn(1, 1'b0, 5'd28, 32'h0, 4'h0, 0, 1'b0, rd, er);
    check("w0_load28", rd, 32'hCAFEF00D);

    // Random traffic with ignored-input noise on both instances.
    for (int n = 0; n < 80; n++) begin
      int d = n % 2;
      logic [4:0] a = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                  : 5'($urandom_range(0, 7) * 4);
      do_txn(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, 3), 1'b1, rd, er);
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
